uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares the single UART transmitter between `NUM_REQ` requesters, such as the register-file read-back path and the ALU result path.
- Grants the transmitter round-robin and holds the grant for a whole multi-byte message, up to the `REQ_LAST` byte.
- Drives the transmitter's parallel-data/valid inputs and paces on its `BUSY` output.
- Sits between the system controller and `UART_TX`, running on the UART transmit clock.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: byte width; must match `UART_TX`.
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `HOLD_TIMEOUT`, default 255: cycles a granted requester may leave `REQ_VALID` low mid-message before the grant is revoked; legal range 1..255.

Ports:
- `CLK`, in, 1: UART TX clock; same clock as `UART_TX`.
- `RST`, in, 1: synchronous, active-high reset.
- `REQ_VALID`, in, `NUM_REQ`: per-requester byte available.
- `REQ_DATA`, in, `NUM_REQ*DATA_WIDTH`: requester i byte on bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `REQ_LAST`, in, `NUM_REQ`: the offered byte is the last of the message.
- `REQ_ACK`, out, `NUM_REQ`: one-cycle pulse; the offered byte was consumed.
- `GRANT`, out, `NUM_REQ`: one-hot owner of the transmitter; all-zero when idle.
- `TX_P_DATA`, out, `DATA_WIDTH`: to `UART_TX.P_DATA`.
- `TX_DATA_VALID`, out, 1: to `UART_TX.DATA_VALID`; one-cycle pulse.
- `TX_BUSY`, in, 1: from `UART_TX.BUSY`.
- `ABORT`, out, 1: one-cycle pulse when a grant is revoked by hold timeout.

## Operation

All outputs are registered. Reset value of every output is 0. The round-robin pointer `PTR` resets to 0.

States:
- IDLE
  - Requires `TX_BUSY`=0 and any `REQ_VALID`.
  - Selects the first set `REQ_VALID` at index `PTR`, `PTR`+1, …, wrapping modulo `NUM_REQ`.
  - Registers `GRANT`, then goes to LOAD.
- LOAD (exactly one cycle)
  - `TX_DATA_VALID`=1, `TX_P_DATA`=byte of the granted requester, `REQ_ACK[g]`=1.
  - Latches `REQ_LAST[g]` into `last_q`, then goes to WAIT_BUSY.
- WAIT_BUSY: stays until `TX_BUSY`=1, then goes to WAIT_DONE.
- WAIT_DONE: stays until `TX_BUSY`=0, then:
  - If `last_q`=1: goes to RELEASE.
  - Else: clears the hold counter and goes to HOLD.
- HOLD
  - If `REQ_VALID[g]`=1: goes to LOAD; the grant is kept.
  - Else: increments the hold counter. When the counter reaches `HOLD_TIMEOUT`, pulses `ABORT` and goes to RELEASE.
  - Other requesters are ignored while in HOLD.
- RELEASE (one cycle): clears `GRANT`, sets `PTR`=(g+1) mod `NUM_REQ`, goes to IDLE.

Rules:
- `REQ_DATA` and `REQ_LAST` are sampled only in the cycle `REQ_ACK` is issued.
  - The requester must hold them stable while `REQ_VALID`=1 and `REQ_ACK`=0.
- Deassertion of `REQ_VALID` before grant is legal. The request is simply not considered.
- With `REQ_VALID` high for both the owner and others at message end, the next grant goes to the next index after the owner, never back to the owner directly.
- Reset mid-message:
  - Returns to IDLE with `GRANT`=0 in the cycle after `RST` is sampled high.
  - No `ACK` or `ABORT` is issued.
  - An in-flight UART frame is the transmitter's concern.
- `TX_BUSY` high while in IDLE: no grant is issued until it falls.

## Timing

- Request sampled in IDLE at cycle n:
  - `GRANT` and the LOAD pulses (`TX_DATA_VALID`, `REQ_ACK`) at n+1.
  - WAIT_BUSY from n+2.
- Back-to-back bytes of one message:
  - `TX_BUSY` falls at cycle m.
  - HOLD at m+1; the next LOAD pulse at m+2 if `REQ_VALID` is high at m+1.
- Message end:
  - `TX_BUSY` falls at m, RELEASE at m+1, IDLE at m+2, next grant at m+3.
- Hold timeout: `ABORT` is issued `HOLD_TIMEOUT`+1 cycles after entering HOLD with `REQ_VALID[g]` continuously low.
- `TX_DATA_VALID` is never asserted while `TX_BUSY`=1.

## Test plan

- **Single byte:** `NUM_REQ`=4; requester 2 offers 0xA5 with `LAST`=1.
  - Expect `GRANT`=0100 one cycle later, one `TX_DATA_VALID` with `TX_P_DATA`=0xA5, `REQ_ACK[2]` pulsed once.
  - `GRANT` returns to 0 one cycle after `BUSY` falls; `PTR`=3.
- **Fairness:** requesters 0 and 3 hold single-byte requests continuously from reset.
  - Expect grant order 0, 3, 0, 3; `ABORT` never asserted.
- **Burst ownership:** requester 1 sends 0x11, 0x22, 0x33 (`LAST` on 0x33) while requester 0 requests throughout.
  - Expect three consecutive frames from requester 1, then requester 0.
- **Hold timeout:** `HOLD_TIMEOUT`=4; requester 2 sends one byte with `LAST`=0, then drops `REQ_VALID`.
  - Expect `ABORT` pulse 5 cycles after HOLD entry, `GRANT` cleared next cycle, `PTR`=3.
- **Reset mid-message:** assert `RST` for one cycle during WAIT_DONE of a 3-byte message.
  - Expect all outputs 0 next cycle and `PTR`=0.
  - A fresh request afterwards is granted normally.
- **Busy gating:** hold `TX_BUSY`=1 while requests are pending.
  - Expect no `GRANT` or `TX_DATA_VALID` until `TX_BUSY`=0, then a grant the following cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ requesters.
// A grant is held for a whole message (up to REQ_LAST) and is revoked after a hold timeout.
module uart_tx_arbiter #(
   parameter int DATA_WIDTH   = 8,
   parameter int NUM_REQ      = 4,
   parameter int HOLD_TIMEOUT = 255
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            REQ_VALID,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]            REQ_LAST,
   output logic [NUM_REQ-1:0]            REQ_ACK,
   output logic [NUM_REQ-1:0]            GRANT,
   output logic [DATA_WIDTH-1:0]         TX_P_DATA,
   output logic                          TX_DATA_VALID,
   input  logic                          TX_BUSY,
   output logic                          ABORT
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1);
   localparam logic [7:0]         HOLD_LIMIT = 8'(HOLD_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_HOLD,
      S_RELEASE
   } state_t;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       ptr, ptr_nxt;
   logic [IDX_W-1:0]       gnt_idx, gnt_idx_nxt;
   logic [IDX_W-1:0]       rr_idx, load_sel;
   logic                   rr_found, do_load;
   int                     rr_cand;
   logic                   last_q, last_nxt;
   logic [7:0]             hold_cnt, hold_cnt_nxt;
   logic [NUM_REQ-1:0]     grant_nxt, ack_nxt, load_onehot;
   logic [DATA_WIDTH-1:0]  pdata_nxt;
   logic                   valid_nxt, abort_nxt;
   logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin search starting at ptr, wrapping modulo NUM_REQ
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_cand  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_cand = int'(ptr) + i;
         if (rr_cand >= NUM_REQ) rr_cand = rr_cand - NUM_REQ;
         if (!rr_found && REQ_VALID[IDX_W'(rr_cand)]) begin
            rr_found = 1'b1;
            rr_idx   = IDX_W'(rr_cand);
         end
      end
   end

   // In HOLD the current owner reloads; in IDLE the round-robin winner does
   assign load_sel    = (state == S_HOLD) ? gnt_idx : rr_idx;
   assign load_onehot = ONE_HOT0 << load_sel;

   always_comb begin
      state_nxt    = state;
      grant_nxt    = GRANT;
      gnt_idx_nxt  = gnt_idx;
      ptr_nxt      = ptr;
      last_nxt     = last_q;
      hold_cnt_nxt = hold_cnt;
      ack_nxt      = '0;
      valid_nxt    = 1'b0;
      pdata_nxt    = TX_P_DATA;
      abort_nxt    = 1'b0;
      do_load      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!TX_BUSY && rr_found) begin
               do_load     = 1'b1;
               gnt_idx_nxt = rr_idx;
               grant_nxt   = load_onehot;
            end
         end
         S_LOAD:      state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: if (TX_BUSY) state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (!TX_BUSY) begin
               if (last_q) begin
                  state_nxt = S_RELEASE;
               end else begin
                  hold_cnt_nxt = '0;
                  state_nxt    = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (REQ_VALID[gnt_idx]) begin
               do_load = 1'b1;
            end else if (hold_cnt == HOLD_LIMIT) begin
               abort_nxt = 1'b1;
               state_nxt = S_RELEASE;
            end else begin
               hold_cnt_nxt = hold_cnt + 8'd1;
            end
         end
         S_RELEASE: begin
            grant_nxt = '0;
            ptr_nxt   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // Byte and its LAST flag are captured in the same cycle the ack pulse is registered
      if (do_load) begin
         state_nxt = S_LOAD;
         ack_nxt   = load_onehot;
         valid_nxt = 1'b1;
         pdata_nxt = req_bytes[load_sel];
         last_nxt  = REQ_LAST[load_sel];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= S_IDLE;
         ptr           <= '0;
         gnt_idx       <= '0;
         last_q        <= 1'b0;
         hold_cnt      <= '0;
         GRANT         <= '0;
         REQ_ACK       <= '0;
         TX_DATA_VALID <= 1'b0;
         TX_P_DATA     <= '0;
         ABORT         <= 1'b0;
      end else begin
         state         <= state_nxt;
         ptr           <= ptr_nxt;
         gnt_idx       <= gnt_idx_nxt;
         last_q        <= last_nxt;
         hold_cnt      <= hold_cnt_nxt;
         GRANT         <= grant_nxt;
         REQ_ACK       <= ack_nxt;
         TX_DATA_VALID <= valid_nxt;
         TX_P_DATA     <= pdata_nxt;
         ABORT         <= abort_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table plus hand-written
// sequences for fairness, burst ownership, hold timeout and reset mid-message.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ack;
   logic [3:0]  grant;
   logic [7:0]  tx_p_data;
   logic        tx_data_valid;
   logic        tx_busy;
   logic        abort;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(
      .DATA_WIDTH  (8),
      .NUM_REQ     (4),
      .HOLD_TIMEOUT(4)
   ) dut (
      .CLK          (clk),
      .RST          (rst),
      .REQ_VALID    (req_valid),
      .REQ_DATA     (req_data),
      .REQ_LAST     (req_last),
      .REQ_ACK      (req_ack),
      .GRANT        (grant),
      .TX_P_DATA    (tx_p_data),
      .TX_DATA_VALID(tx_data_valid),
      .TX_BUSY      (tx_busy),
      .ABORT        (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic [31:0] d;
      logic [3:0]  l;
      logic        busy;
      logic [3:0]  g;
      logic [3:0]  a;
      logic        tv;
      logic [7:0]  pd;
      logic        ab;
      logic [1:0]  ptr;
   } vec_t;

   vec_t tbl [20];

   int pulse_g [$];
   int pulse_d [$];
   int pulse_c [$];
   int n_abort;
   int busy_cnt;
   int b1_idx;
   bit r0_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_busy   = 1'b0;
      busy_cnt  = 0;
      tick();
      rst = 1'b0;
   endtask

   function automatic int idx_of(input logic [3:0] oh);
      int r = -1;
      for (int i = 0; i < 4; i++) if (oh[i]) r = i;
      return r;
   endfunction

   // Cycle loop with a 3-cycle UART busy model; mode 1 plays requester 1's burst
   task automatic run_until(input int want, input int budget, input int mode, input string tag);
      int cyc = 0;
      pulse_g.delete();
      pulse_d.delete();
      pulse_c.delete();
      n_abort = 0;
      while (pulse_g.size() < want && cyc < budget) begin
         tick();
         cyc++;
         if (tx_data_valid) begin
            chk({tag, "_busy_at_load"}, {31'd0, tx_busy}, 32'd0);
            chk({tag, "_grant_eq_ack"}, {28'd0, grant}, {28'd0, req_ack});
            pulse_g.push_back(idx_of(req_ack));
            pulse_d.push_back(int'(tx_p_data));
            pulse_c.push_back(cyc);
            busy_cnt = 3;
         end
         if (abort) n_abort++;
         if (mode == 1) begin
            if (req_ack[1]) begin
               b1_idx++;
               case (b1_idx)
                  1: begin req_data[15:8] = 8'h22; req_last[1] = 1'b0; end
                  2: begin req_data[15:8] = 8'h33; req_last[1] = 1'b1; end
                  default: req_valid[1] = 1'b0;
               endcase
            end
            if (req_ack[0]) r0_done = 1'b1;
            req_valid[0] = (pulse_g.size() >= 1) && !r0_done;
         end
         if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
         end else begin
            tx_busy = 1'b0;
         end
      end
      chk({tag, "_pulse_count"}, pulse_g.size(), want);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_busy   = 1'b0;

      // rst v d l busy | grant ack tv pdata abort ptr
      tbl[0]  = '{1'b1, 4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
      tbl[1]  = '{1'b0, 4'b0100, 32'h00A50000, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA5, 1'b0, 2'd0};
      tbl[2]  = '{1'b0, 4'b0000, 32'h00A50000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0};
      tbl[3]  = '{1'b0, 4'b0000, 32'h00A50000, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0};
      tbl[4]  = '{1'b0, 4'b0000, 32'h00A50000, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0};
      tbl[5]  = '{1'b0, 4'b0000, 32'h00A50000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0};
      tbl[6]  = '{1'b0, 4'b0000, 32'h00A50000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd3};
      tbl[7]  = '{1'b0, 4'b1111, 32'hD3C2B1A0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd3};
      tbl[8]  = '{1'b0, 4'b1111, 32'hD3C2B1A0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd3};
      tbl[9]  = '{1'b0, 4'b1111, 32'hD3C2B1A0, 4'b1111, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'hD3, 1'b0, 2'd3};
      tbl[10] = '{1'b0, 4'b0111, 32'hD3C2B1A0, 4'b1111, 1'b0, 4'b1000, 4'b0000, 1'b0, 8'hD3, 1'b0, 2'd3};
      tbl[11] = '{1'b0, 4'b0111, 32'hD3C2B1A0, 4'b1111, 1'b1, 4'b1000, 4'b0000, 1'b0, 8'hD3, 1'b0, 2'd3};
      tbl[12] = '{1'b0, 4'b0111, 32'hD3C2B1A0, 4'b1111, 1'b0, 4'b1000, 4'b0000, 1'b0, 8'hD3, 1'b0, 2'd3};
      tbl[13] = '{1'b0, 4'b0111, 32'hD3C2B1A0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hD3, 1'b0, 2'd0};
      tbl[14] = '{1'b0, 4'b0111, 32'hD3C2B1A0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0, 1'b0, 2'd0};
      tbl[15] = '{1'b0, 4'b0110, 32'hD3C2B1A0, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'hA0, 1'b0, 2'd0};
      tbl[16] = '{1'b0, 4'b0110, 32'hD3C2B1A0, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'hA0, 1'b0, 2'd0};
      tbl[17] = '{1'b0, 4'b0110, 32'hD3C2B1A0, 4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA0, 1'b0, 2'd0};
      tbl[18] = '{1'b0, 4'b0110, 32'hD3C2B1A0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA0, 1'b0, 2'd1};
      tbl[19] = '{1'b0, 4'b0000, 32'hD3C2B1A0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA0, 1'b0, 2'd1};

      // Single byte, busy gating and pointer wrap
      for (int i = 0; i < 20; i++) begin
         rst       = tbl[i].rst;
         req_valid = tbl[i].v;
         req_data  = tbl[i].d;
         req_last  = tbl[i].l;
         tx_busy   = tbl[i].busy;
         tick();
         chk($sformatf("row%0d_grant", i), {28'd0, grant},   {28'd0, tbl[i].g});
         chk($sformatf("row%0d_ack", i),   {28'd0, req_ack}, {28'd0, tbl[i].a});
         chk($sformatf("row%0d_txv", i),   {31'd0, tx_data_valid}, {31'd0, tbl[i].tv});
         chk($sformatf("row%0d_pdata", i), {24'd0, tx_p_data}, {24'd0, tbl[i].pd});
         chk($sformatf("row%0d_abort", i), {31'd0, abort}, {31'd0, tbl[i].ab});
         chk($sformatf("row%0d_ptr", i),   {30'd0, dut.ptr}, {30'd0, tbl[i].ptr});
      end

      // Fairness: requesters 0 and 3 request continuously
      do_reset();
      req_valid = 4'b1001;
      req_last  = 4'b1001;
      req_data  = 32'h13000010;
      run_until(4, 60, 0, "fair");
      if (pulse_g.size() == 4) begin
         chk("fair_g0", pulse_g[0], 0);
         chk("fair_g1", pulse_g[1], 3);
         chk("fair_g2", pulse_g[2], 0);
         chk("fair_g3", pulse_g[3], 3);
         chk("fair_d1", pulse_d[1], 32'h13);
         for (int k = 1; k < 4; k++)
            chk($sformatf("fair_gap%0d", k), pulse_c[k] - pulse_c[k-1], 6);
      end
      chk("fair_no_abort", n_abort, 0);

      // Burst: requester 1 owns the transmitter for 3 bytes while requester 0 waits
      do_reset();
      b1_idx    = 0;
      r0_done   = 1'b0;
      req_valid = 4'b0010;
      req_last  = 4'b0001;
      req_data  = 32'h00001140;
      run_until(4, 80, 1, "burst");
      if (pulse_g.size() == 4) begin
         chk("burst_g0", pulse_g[0], 1);
         chk("burst_g1", pulse_g[1], 1);
         chk("burst_g2", pulse_g[2], 1);
         chk("burst_g3", pulse_g[3], 0);
         chk("burst_d0", pulse_d[0], 32'h11);
         chk("burst_d1", pulse_d[1], 32'h22);
         chk("burst_d2", pulse_d[2], 32'h33);
         chk("burst_d3", pulse_d[3], 32'h40);
         chk("burst_gap1", pulse_c[1] - pulse_c[0], 5);
         chk("burst_gap2", pulse_c[2] - pulse_c[1], 5);
         chk("burst_gap3", pulse_c[3] - pulse_c[2], 6);
      end
      chk("burst_no_abort", n_abort, 0);

      // Hold timeout: owner goes quiet mid-message
      do_reset();
      req_valid = 4'b0100;
      req_data  = 32'h005A0000;
      req_last  = 4'b0000;
      tick();
      chk("to_load_grant", {28'd0, grant}, 32'h4);
      chk("to_load_pdata", {24'd0, tx_p_data}, 32'h5A);
      req_valid = 4'b0000;
      tx_busy   = 1'b1;
      tick();
      tick();
      tx_busy = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("to_hold%0d_abort", k), {31'd0, abort}, 32'd0);
         chk($sformatf("to_hold%0d_grant", k), {28'd0, grant}, 32'h4);
         tick();
      end
      chk("to_abort_pulse", {31'd0, abort}, 32'd1);
      chk("to_abort_grant", {28'd0, grant}, 32'h4);
      tick();
      chk("to_after_abort", {31'd0, abort}, 32'd0);
      chk("to_after_grant", {28'd0, grant}, 32'd0);
      chk("to_after_ptr", {30'd0, dut.ptr}, 32'd3);

      // Reset in WAIT_DONE of a 3-byte message
      do_reset();
      req_valid = 4'b0010;
      req_data  = 32'h00001100;
      req_last  = 4'b0000;
      tick();
      chk("rm_load_grant", {28'd0, grant}, 32'h2);
      req_data[15:8] = 8'h22;
      tx_busy = 1'b1;
      tick();
      tick();
      tick();
      chk("rm_wait_grant", {28'd0, grant}, 32'h2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rm_rst_grant", {28'd0, grant}, 32'd0);
      chk("rm_rst_ack",   {28'd0, req_ack}, 32'd0);
      chk("rm_rst_txv",   {31'd0, tx_data_valid}, 32'd0);
      chk("rm_rst_pdata", {24'd0, tx_p_data}, 32'd0);
      chk("rm_rst_abort", {31'd0, abort}, 32'd0);
      chk("rm_rst_ptr",   {30'd0, dut.ptr}, 32'd0);
      req_valid = 4'b1000;
      req_data  = 32'h77000000;
      req_last  = 4'b1000;
      tx_busy   = 1'b0;
      tick();
      chk("rm_fresh_grant", {28'd0, grant}, 32'h8);
      chk("rm_fresh_ack",   {28'd0, req_ack}, 32'h8);
      chk("rm_fresh_txv",   {31'd0, tx_data_valid}, 32'd1);
      chk("rm_fresh_pdata", {24'd0, tx_p_data}, 32'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
